// File: rtl/grid_vga_renderer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : grid_vga_renderer
//  Brief    : Renders the packed snake-game block grid as a VGA stream
//             (640x480@60 Hz by default). The grid is snapshotted once per
//             frame in vertical blanking so a frame never tears, and each
//             block code is mapped to an RRRGGGBB colour through a 2-stage
//             pipeline that keeps colour and syncs aligned.
//  Revision : 1.0 - initial release
// ============================================================================
module grid_vga_renderer #(
    parameter int GRID_WIDTH  = 40,
    parameter int GRID_HEIGHT = 30,
    parameter int CELL_PX     = 16,
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic [0:2*GRID_WIDTH*GRID_HEIGHT-1]   i_blocks,
    output logic [0:7]                            o_rgb,
    output logic                                  o_hsync,
    output logic                                  o_vsync,
    output logic                                  o_frame_start
);

    localparam int c_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int c_HW      = $clog2(c_H_TOTAL);
    localparam int c_VW      = $clog2(c_V_TOTAL);
    localparam int c_SUBW    = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
    localparam int c_BITS    = 2 * GRID_WIDTH * GRID_HEIGHT;
    localparam int c_IDXW    = (c_BITS > 2) ? $clog2(c_BITS) : 1;

    localparam logic [c_HW-1:0]   c_H_LAST   = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_HW-1:0]   c_H_VIS    = c_HW'(H_VISIBLE);
    localparam logic [c_HW-1:0]   c_H_GRID   = c_HW'(GRID_WIDTH * CELL_PX);
    localparam logic [c_HW-1:0]   c_HS_START = c_HW'(H_VISIBLE + H_FRONT);
    localparam logic [c_HW-1:0]   c_HS_END   = c_HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [c_VW-1:0]   c_V_LAST   = c_VW'(c_V_TOTAL - 1);
    localparam logic [c_VW-1:0]   c_V_VIS    = c_VW'(V_VISIBLE);
    localparam logic [c_VW-1:0]   c_V_LOAD   = c_VW'(V_VISIBLE - 1);
    localparam logic [c_VW-1:0]   c_V_GRID   = c_VW'(GRID_HEIGHT * CELL_PX);
    localparam logic [c_VW-1:0]   c_VS_START = c_VW'(V_VISIBLE + V_FRONT);
    localparam logic [c_VW-1:0]   c_VS_END   = c_VW'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [c_SUBW-1:0] c_SUB_LAST = c_SUBW'(CELL_PX - 1);

    // Counters and cell trackers
    logic              r_run;
    logic [c_HW-1:0]   r_hcnt;
    logic [c_VW-1:0]   r_vcnt;
    logic [c_SUBW-1:0] r_col_sub;
    logic [c_HW-1:0]   r_col;
    logic [c_SUBW-1:0] r_row_sub;
    logic [c_VW-1:0]   r_row;

    // Frame snapshot, same bit ordering as i_blocks
    logic [0:c_BITS-1] r_snap;

    // Pipeline stage 1
    logic [1:0]        r_s1_code;
    logic              r_s1_vis;
    logic              r_s1_hs;
    logic              r_s1_vs;

    logic              w_load;
    logic              w_in_grid;
    logic [c_IDXW-1:0] w_bit_lo;
    logic [c_IDXW-1:0] w_bit_hi;
    logic [1:0]        w_code;
    logic [0:7]        w_colour;

    // Raster counters; the first edge after reset only arms r_run so that
    // counter value k is present right after edge k.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run     <= 1'b0;
            r_hcnt    <= '0;
            r_vcnt    <= '0;
            r_col_sub <= '0;
            r_col     <= '0;
            r_row_sub <= '0;
            r_row     <= '0;
        end else if (!r_run) begin
            r_run <= 1'b1;
        end else if (r_hcnt == c_H_LAST) begin
            r_hcnt    <= '0;
            r_col_sub <= '0;
            r_col     <= '0;
            if (r_vcnt == c_V_LAST) begin
                r_vcnt    <= '0;
                r_row_sub <= '0;
                r_row     <= '0;
            end else begin
                r_vcnt <= r_vcnt + 1'b1;
                if (r_row_sub == c_SUB_LAST) begin
                    r_row_sub <= '0;
                    r_row     <= r_row + 1'b1;
                end else begin
                    r_row_sub <= r_row_sub + 1'b1;
                end
            end
        end else begin
            r_hcnt <= r_hcnt + 1'b1;
            if (r_col_sub == c_SUB_LAST) begin
                r_col_sub <= '0;
                r_col     <= r_col + 1'b1;
            end else begin
                r_col_sub <= r_col_sub + 1'b1;
            end
        end
    end

    // Load on the edge that enters (hcnt=0, vcnt=V_VISIBLE): start of vblank
    assign w_load = r_run && (r_hcnt == c_H_LAST) && (r_vcnt == c_V_LOAD);

    // Snapshot register and frame-start pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_snap        <= '0;
            o_frame_start <= 1'b0;
        end else begin
            o_frame_start <= w_load;
            if (w_load) begin
                r_snap <= i_blocks;
            end
        end
    end

    // Current pixel lies in the visible area and inside the drawn grid
    assign w_in_grid = r_run
                    && (r_hcnt < c_H_VIS) && (r_vcnt < c_V_VIS)
                    && (r_hcnt < c_H_GRID) && (r_vcnt < c_V_GRID);

    // Select the 2-bit block code of the current cell from the snapshot
    always_comb begin
        w_bit_lo = '0;
        if (w_in_grid) begin
            w_bit_lo = c_IDXW'((int'(r_row) * GRID_WIDTH + int'(r_col)) * 2);
        end
        w_bit_hi = w_bit_lo | c_IDXW'(1);
        w_code   = {r_snap[w_bit_hi], r_snap[w_bit_lo]};
    end

    // Stage 1: cell code, visibility and raw sync levels
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_code <= 2'd0;
            r_s1_vis  <= 1'b0;
            r_s1_hs   <= 1'b1;
            r_s1_vs   <= 1'b1;
        end else begin
            r_s1_code <= w_code;
            r_s1_vis  <= w_in_grid;
            r_s1_hs   <= !((r_hcnt >= c_HS_START) && (r_hcnt < c_HS_END));
            r_s1_vs   <= !((r_vcnt >= c_VS_START) && (r_vcnt < c_VS_END));
        end
    end

    // Block code to RRRGGGBB colour
    always_comb begin
        w_colour = 8'b0000_0000;
        case (r_s1_code)
            2'd1:    w_colour = 8'b0001_1100;
            2'd2:    w_colour = 8'b1110_0000;
            2'd3:    w_colour = 8'b1001_0010;
            default: w_colour = 8'b0000_0000;
        endcase
    end

    // Stage 2: blanked colour and delayed syncs to the pins
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rgb   <= '0;
            o_hsync <= 1'b1;
            o_vsync <= 1'b1;
        end else begin
            o_rgb   <= r_s1_vis ? w_colour : 8'b0000_0000;
            o_hsync <= r_s1_hs;
            o_vsync <= r_s1_vs;
        end
    end

endmodule
`default_nettype wire
